// File: rtl/mux_tree_pkg.sv
// Shared types and helpers for the pipelined mux tree.
package mux_tree_pkg;

  // Widest select carried in a stage record (N_IN up to 64).
  localparam int MAX_SEL_W = 6;

  // Tree depth / select width, never below one level.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Lane count after zero-padding to a full binary tree.
  function automatic int pad_n(input int n);
    return 1 << sel_width(n);
  endfunction

  // Control record that travels alongside the data through every level.
  typedef struct packed {
    logic                 valid;
    logic [MAX_SEL_W-1:0] sel;
    logic                 oor;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{valid: 1'b0, sel: '0, oor: 1'b0};

endpackage

// File: rtl/mux_tree_level.sv
// One registered 2:1 level of the mux tree: halves the lane count using
// select bit J and forwards the stage record.
module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int N_LN  = 2,
  parameter int W     = 8,
  parameter int SEL_W = 1,
  parameter int J     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  stage_t                  in_st,
  input  logic [N_LN*W-1:0]       in_data,
  output stage_t                  out_st,
  output logic [(N_LN/2)*W-1:0]   out_data
);

  localparam int N_OUT = N_LN / 2;
  // Clamp keeps the bit index legal if a level is ever built past the tree depth.
  localparam int SB    = (J < SEL_W) ? J : SEL_W - 1;

  logic [N_OUT*W-1:0] nxt_data;

  // Pairwise lane pick: odd lane of each pair when the level's select bit is set.
  always_comb begin
    nxt_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      nxt_data[i*W +: W] = in_st.sel[SB] ? in_data[(2*i+1)*W +: W]
                                         : in_data[(2*i)*W +: W];
    end
  end

  // Valid always advances; payload only loads behind a valid, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_st   <= STAGE_IDLE;
      out_data <= '0;
    end else begin
      out_st.valid <= in_st.valid;
      if (in_st.valid) begin
        out_st.sel <= in_st.sel;
        out_st.oor <= in_st.oor;
        out_data   <= nxt_data;
      end
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 mux of W-bit lanes built from SEL_W registered 2:1 levels,
// with out-of-range flagging and an optional internal scan select.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter  int N_IN  = 5,
  parameter  int W     = 8,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              scan_en,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_oor
);

  localparam int PAD_N = pad_n(N_IN);

  logic [SEL_W-1:0]   scan_cnt;
  logic [SEL_W-1:0]   eff_sel;
  logic [PAD_N*W-1:0] pad_data;
  stage_t             st_in;

  assign eff_sel = scan_en ? scan_cnt : in_sel;

  // Stage-0 record: select and range flag are fixed at launch and travel with the data.
  always_comb begin
    st_in       = STAGE_IDLE;
    st_in.valid = in_valid;
    st_in.sel   = MAX_SEL_W'(eff_sel);
    st_in.oor   = (int'(eff_sel) >= N_IN);
  end

  // Zero-pad the lane vector up to a power of two.
  if (PAD_N > N_IN) begin : g_pad
    assign pad_data = {{((PAD_N - N_IN) * W){1'b0}}, in_data};
  end else begin : g_nopad
    assign pad_data = in_data;
  end

  // Scan counter walks the legal lanes only, advancing once per accepted scan vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (in_valid && scan_en) begin
      scan_cnt <= (scan_cnt == SEL_W'(N_IN - 1)) ? '0 : scan_cnt + 1'b1;
    end
  end

  // Tree levels; the input to the last level is zeroed for out-of-range selects
  // so padded lanes and aliased codes both come out as 0.
  for (genvar j = 0; j < SEL_W; j++) begin : g_lvl
    localparam int NL = PAD_N >> j;

    logic [NL*W-1:0]     src;
    logic [NL*W-1:0]     din;
    logic [(NL/2)*W-1:0] dout;
    stage_t              sin;
    stage_t              sout;

    if (j == 0) begin : g_first
      assign src = pad_data;
      assign sin = st_in;
    end else begin : g_chain
      assign src = g_lvl[j-1].dout;
      assign sin = g_lvl[j-1].sout;
    end

    if (j == SEL_W - 1) begin : g_last
      assign din = sin.oor ? '0 : src;
    end else begin : g_mid
      assign din = src;
    end

    mux_tree_level #(
      .N_LN  (NL),
      .W     (W),
      .SEL_W (SEL_W),
      .J     (j)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_st    (sin),
      .in_data  (din),
      .out_st   (sout),
      .out_data (dout)
    );
  end

  assign out_valid = g_lvl[SEL_W-1].sout.valid;
  assign out_data  = g_lvl[SEL_W-1].dout;
  assign out_sel   = g_lvl[SEL_W-1].sout.sel[SEL_W-1:0];
  assign out_oor   = g_lvl[SEL_W-1].sout.oor;

endmodule
